// File: rtl/counter_wrap_monitor.sv
// Watches an upstream 4-bit counter, counts its 15->0 wraps and flags any
// break in its count sequence or overflow flag.
module counter_wrap_monitor #(
    parameter int WRAP_LIMIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       cnt_reset,
    input  logic       cnt_enable,
    input  logic [3:0] counter_in,
    input  logic       overflow_in,
    output logic [7:0] wrap_count,
    output logic       alarm,
    output logic       seq_fault,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ALARM = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam logic [7:0] LIMIT = 8'(WRAP_LIMIT);

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_wrap_count;
    logic [7:0] w_wrap_nx;
    logic       r_alarm;
    logic       w_alarm_nx;
    logic       r_seq_fault;
    logic       w_fault_nx;
    logic [3:0] r_prev_count;
    logic       r_prev_en;
    logic       r_prev_rst;
    logic       r_prev_valid;

    logic [3:0] w_expected;
    logic       w_seq_err;
    logic       w_flag_err;
    logic       w_err;
    logic       w_wrap;
    logic [7:0] w_wrap_inc;

    always_comb begin
        if (r_prev_rst)
            w_expected = 4'd0;
        else if (r_prev_en)
            w_expected = r_prev_count + 4'd1;
        else
            w_expected = r_prev_count;
    end

    assign w_seq_err  = r_prev_valid && (counter_in != w_expected);
    assign w_flag_err = overflow_in != (counter_in == 4'd15);
    assign w_err      = w_seq_err || w_flag_err;

    assign w_wrap = r_prev_valid && (r_prev_count == 4'd15) && r_prev_en
                 && !r_prev_rst && (counter_in == 4'd0) && !w_err;

    // Saturate rather than roll over so a long run never hides the alarm
    assign w_wrap_inc = (r_wrap_count == 8'hFF) ? r_wrap_count
                                                : r_wrap_count + 8'd1;

    always_comb begin
        w_state_nx = r_state;
        w_wrap_nx  = r_wrap_count;
        w_alarm_nx = r_alarm;
        w_fault_nx = r_seq_fault;
        if (clear) begin
            w_state_nx = IDLE;
            w_wrap_nx  = 8'd0;
            w_alarm_nx = 1'b0;
            w_fault_nx = 1'b0;
        end else if (r_state == FAULT) begin
            w_state_nx = FAULT;
        end else if (w_err) begin
            w_state_nx = FAULT;
            w_fault_nx = 1'b1;
        end else begin
            if (w_wrap)
                w_wrap_nx = w_wrap_inc;
            w_alarm_nx = (w_wrap_nx >= LIMIT);
            unique case (r_state)
                IDLE:  if (cnt_enable) w_state_nx = TRACK;
                TRACK: if (w_wrap_nx >= LIMIT) w_state_nx = ALARM;
                ALARM: w_state_nx = ALARM;
                FAULT: w_state_nx = FAULT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_wrap_count <= 8'd0;
            r_alarm      <= 1'b0;
            r_seq_fault  <= 1'b0;
            r_prev_count <= 4'd0;
            r_prev_en    <= 1'b0;
            r_prev_rst   <= 1'b0;
            r_prev_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_wrap_count <= w_wrap_nx;
            r_alarm      <= w_alarm_nx;
            r_seq_fault  <= w_fault_nx;
            r_prev_count <= counter_in;
            r_prev_en    <= cnt_enable;
            r_prev_rst   <= cnt_reset;
            r_prev_valid <= !clear;
        end
    end

    assign wrap_count = r_wrap_count;
    assign alarm      = r_alarm;
    assign seq_fault  = r_seq_fault;
    assign state      = r_state;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed bench for counter_wrap_monitor: vector table plus
// multi-cycle sequences on three WRAP_LIMIT settings.
module tb_counter_wrap_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       clear;
    logic       cnt_reset;
    logic       cnt_enable;
    logic [3:0] counter_in;
    logic       overflow_in;

    logic [7:0] d_wrap, a_wrap, s_wrap;
    logic       d_alarm, a_alarm, s_alarm;
    logic       d_fault, a_fault, s_fault;
    logic [1:0] d_state, a_state, s_state;

    int checks = 0;
    int failures = 0;
    logic [3:0] up = 4'd0;

    always #5 clk = ~clk;

    counter_wrap_monitor u_def (
        .clk(clk), .reset(reset), .clear(clear),
        .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
        .counter_in(counter_in), .overflow_in(overflow_in),
        .wrap_count(d_wrap), .alarm(d_alarm),
        .seq_fault(d_fault), .state(d_state)
    );

    counter_wrap_monitor #(.WRAP_LIMIT(2)) u_l2 (
        .clk(clk), .reset(reset), .clear(clear),
        .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
        .counter_in(counter_in), .overflow_in(overflow_in),
        .wrap_count(a_wrap), .alarm(a_alarm),
        .seq_fault(a_fault), .state(a_state)
    );

    counter_wrap_monitor #(.WRAP_LIMIT(255)) u_l255 (
        .clk(clk), .reset(reset), .clear(clear),
        .cnt_reset(cnt_reset), .cnt_enable(cnt_enable),
        .counter_in(counter_in), .overflow_in(overflow_in),
        .wrap_count(s_wrap), .alarm(s_alarm),
        .seq_fault(s_fault), .state(s_state)
    );

    typedef struct {
        logic       clr;
        logic       en;
        logic       rs;
        logic [3:0] cin;
        logic       ovf;
        logic [7:0] wrap;
        logic       alarm;
        logic       fault;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic c, input logic e,
                                input logic r, input logic [3:0] ci,
                                input logic o, input logic [7:0] w,
                                input logic a, input logic f,
                                input logic [1:0] s);
        vec_t v;
        v.clr = c; v.en = e; v.rs = r; v.cin = ci; v.ovf = o;
        v.wrap = w; v.alarm = a; v.fault = f; v.st = s;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Upstream counter model: values sampled at the edge, then advanced
    task automatic cyc(input logic c, input logic e, input logic r);
        clear       = c;
        cnt_enable  = e;
        cnt_reset   = r;
        counter_in  = up;
        overflow_in = (up == 4'd15);
        @(posedge clk);
        if (r)      up = 4'd0;
        else if (e) up = up + 4'd1;
        #1;
    endtask

    initial begin
        reset = 1'b0; clear = 1'b0; cnt_reset = 1'b0;
        cnt_enable = 1'b0; counter_in = 4'd0; overflow_in = 1'b0;

        tbl[0]  = mk(0, 0, 1, 4'd0,  0, 8'd0, 0, 0, 2'd0);
        tbl[1]  = mk(0, 1, 0, 4'd0,  0, 8'd0, 0, 0, 2'd1);
        tbl[2]  = mk(0, 1, 0, 4'd1,  0, 8'd0, 0, 0, 2'd1);
        tbl[3]  = mk(0, 0, 0, 4'd2,  0, 8'd0, 0, 0, 2'd1);
        tbl[4]  = mk(0, 0, 0, 4'd2,  0, 8'd0, 0, 0, 2'd1);
        tbl[5]  = mk(0, 1, 1, 4'd2,  0, 8'd0, 0, 0, 2'd1);
        tbl[6]  = mk(0, 1, 0, 4'd0,  0, 8'd0, 0, 0, 2'd1);
        tbl[7]  = mk(0, 1, 0, 4'd1,  1, 8'd0, 0, 1, 2'd3);
        tbl[8]  = mk(0, 1, 0, 4'd2,  0, 8'd0, 0, 1, 2'd3);
        tbl[9]  = mk(1, 0, 0, 4'd5,  0, 8'd0, 0, 0, 2'd0);
        tbl[10] = mk(0, 0, 0, 4'd9,  1, 8'd0, 0, 1, 2'd3);
        tbl[11] = mk(1, 0, 0, 4'd9,  0, 8'd0, 0, 0, 2'd0);
        tbl[12] = mk(0, 1, 0, 4'd15, 1, 8'd0, 0, 0, 2'd1);
        tbl[13] = mk(0, 1, 0, 4'd0,  0, 8'd1, 0, 0, 2'd1);
        tbl[14] = mk(0, 1, 0, 4'd2,  0, 8'd1, 0, 1, 2'd3);
        tbl[15] = mk(1, 0, 0, 4'd0,  0, 8'd0, 0, 0, 2'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_wrap", d_wrap, 0);
        chk("rst_alarm", d_alarm, 0);
        chk("rst_fault", d_fault, 0);
        chk("rst_state", d_state, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) begin
            clear       = tbl[i].clr;
            cnt_enable  = tbl[i].en;
            cnt_reset   = tbl[i].rs;
            counter_in  = tbl[i].cin;
            overflow_in = tbl[i].ovf;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wrap", i), d_wrap, tbl[i].wrap);
            chk($sformatf("v%0d_alarm", i), d_alarm, tbl[i].alarm);
            chk($sformatf("v%0d_fault", i), d_fault, tbl[i].fault);
            chk($sformatf("v%0d_state", i), d_state, tbl[i].st);
        end

        // First wrap after a cnt_reset pulse
        up = 4'd0;
        cyc(0, 0, 1);
        repeat (16) cyc(0, 1, 0);
        chk("a_prewrap", d_wrap, 0);
        cyc(0, 1, 0);
        chk("a_wrap1", d_wrap, 1);
        chk("a_state1", d_state, 1);
        chk("a_fault1", d_fault, 0);
        chk("l2_wrap1_alarm", a_alarm, 0);
        repeat (15) cyc(0, 1, 0);
        chk("l2_prewrap2", a_wrap, 1);
        chk("l2_prewrap2_st", a_state, 1);
        cyc(0, 1, 0);
        chk("l2_wrap2", a_wrap, 2);
        chk("l2_alarm", a_alarm, 1);
        chk("l2_state_alarm", a_state, 2);
        chk("def_wrap2_st", d_state, 1);
        repeat (5) cyc(0, 0, 0);
        chk("l2_hold_st", a_state, 2);
        chk("l2_hold_fault", a_fault, 0);
        chk("l2_hold_wrap", a_wrap, 2);

        // cnt_reset mid-run at count 9
        while (up != 4'd9) cyc(0, 1, 0);
        cyc(0, 1, 1);
        cyc(0, 1, 0);
        chk("crst_fault", d_fault, 0);
        chk("crst_wrap", d_wrap, 2);
        chk("crst_state", d_state, 1);
        chk("crst_l2_state", a_state, 2);

        // Asynchronous reset between edges while in ALARM
        #2;
        reset = 1'b0;
        #1;
        chk("async_wrap", a_wrap, 0);
        chk("async_alarm", a_alarm, 0);
        chk("async_fault", a_fault, 0);
        chk("async_state", a_state, 0);
        @(negedge clk);
        reset = 1'b1;

        // Sequence jump 5 -> 7 freezes the monitor
        cyc(0, 0, 1);
        while (up != 4'd6) cyc(0, 1, 0);
        up = 4'd7;
        cyc(0, 1, 0);
        chk("jump_fault", d_fault, 1);
        chk("jump_state", d_state, 3);
        repeat (40) cyc(0, 1, 0);
        chk("frozen_wrap", d_wrap, 0);
        chk("frozen_state", d_state, 3);
        chk("frozen_fault", d_fault, 1);
        cyc(1, 0, 0);
        chk("clr_wrap", d_wrap, 0);
        chk("clr_alarm", d_alarm, 0);
        chk("clr_fault", d_fault, 0);
        chk("clr_state", d_state, 0);

        // 300 wraps against WRAP_LIMIT=255
        cyc(0, 0, 1);
        repeat (254 * 16 + 1) cyc(0, 1, 0);
        chk("sat254_wrap", s_wrap, 254);
        chk("sat254_alarm", s_alarm, 0);
        chk("sat254_state", s_state, 1);
        repeat (16) cyc(0, 1, 0);
        chk("sat255_wrap", s_wrap, 255);
        chk("sat255_alarm", s_alarm, 1);
        chk("sat255_state", s_state, 2);
        repeat (45 * 16) cyc(0, 1, 0);
        chk("sat300_wrap", s_wrap, 255);
        chk("sat300_alarm", s_alarm, 1);
        chk("sat300_def_wrap", d_wrap, 255);

        // Fault while alarmed keeps alarm and count
        up = up + 4'd3;
        cyc(0, 1, 0);
        chk("fa_state", s_state, 3);
        chk("fa_alarm", s_alarm, 1);
        chk("fa_wrap", s_wrap, 255);
        chk("fa_fault", s_fault, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_wrap_monitor.md
COUNTER_WRAP_MONITOR -- requirements
Module: counter_wrap_monitor

Interface
REQ-001 Parameter WRAP_LIMIT, default 8, wrap count (1..255) at which alarm asserts.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; asserted (0) forces the reset state immediately, released synchronously to clk.
REQ-004 clear  input  1  synchronous clear of counts, faults and state.
REQ-005 cnt_reset  input  1  copy of the upstream 4-bit counter's synchronous reset.
REQ-006 cnt_enable  input  1  copy of the upstream counter's enable.
REQ-007 counter_in  input  4  upstream counter value.
REQ-008 overflow_in  input  1  upstream overflow flag; high while counter_in == 15.
REQ-009 wrap_count  output  8  number of 15->0 wraps observed, saturating.
REQ-010 alarm  output  1  high while wrap_count >= WRAP_LIMIT.
REQ-011 seq_fault  output  1  sticky: upstream sequence or flag inconsistency detected.
REQ-012 state  output  2  FSM state: 0 IDLE, 1 TRACK, 2 ALARM, 3 FAULT.

Function
REQ-013 All outputs SHALL be registered; no combinational input-to-output path.
REQ-014 Each rising edge SHALL sample counter_in, overflow_in, cnt_enable, cnt_reset into prev_count, prev_en, prev_rst, and set prev_valid=1.
REQ-015 Expected value when prev_valid=1: prev_rst=1 -> 0; else prev_en=1 -> (prev_count+1) mod 16; else prev_count.
REQ-016 Sequence error SHALL be flagged when prev_valid=1 and counter_in != expected value.
REQ-017 Flag error SHALL be flagged when overflow_in != (counter_in == 15), checked every cycle, including prev_valid=0.
REQ-018 Wrap event SHALL be prev_valid=1, prev_count=15, prev_en=1, prev_rst=0, counter_in=0, no error this cycle.
REQ-019 wrap_count SHALL increment by 1 on each wrap event, hold at 255 (no wrap-around), and be visible the cycle after the event edge (latency 1).
REQ-020 IDLE -> TRACK on first cycle with cnt_enable=1 and no error.
REQ-021 TRACK -> ALARM when the updated wrap_count >= WRAP_LIMIT; alarm asserts in the same cycle state becomes ALARM.
REQ-022 ALARM SHALL persist; wrap counting continues in ALARM.
REQ-023 Any error in IDLE, TRACK or ALARM SHALL move to FAULT and set seq_fault=1 next cycle.
REQ-024 In FAULT: wrap_count frozen, seq_fault held, alarm holds its last value; exit only via clear or reset.
REQ-025 cnt_reset=1 alone SHALL NOT be an error and SHALL NOT clear wrap_count.
REQ-026 clear=1 SHALL, at that edge: state=IDLE, wrap_count=0, alarm=0, seq_fault=0, prev_valid=0; clear has priority over error detection and wrap counting in the same cycle.
REQ-027 Priority: reset > clear > error detection > wrap counting.

Reset
REQ-028 reset=0 SHALL asynchronously force state=IDLE, wrap_count=0, alarm=0, seq_fault=0, prev_valid=0, prev_count=0, prev_en=0, prev_rst=0.
REQ-029 reset asserted mid-operation, including in ALARM or FAULT, SHALL take effect without waiting for clk.
REQ-030 First edge after reset release SHALL perform no sequence check (prev_valid=0).

Verification
REQ-031 Reset, cnt_reset pulse, then enable 17 cycles from 0 -> wrap_count=1 one cycle after the 15->0 sample, state=TRACK, seq_fault=0.
REQ-032 WRAP_LIMIT=2, enable 40 cycles -> wrap_count=2 after second wrap, alarm=1, state=ALARM; disabling enable holds counter, no fault.
REQ-033 Counter jumps 5->7 with enable=1 -> seq_fault=1, state=FAULT next cycle; further wraps leave wrap_count unchanged.
REQ-034 overflow_in=1 while counter_in=9 -> seq_fault=1, state=FAULT; then clear=1 -> all outputs 0, state=IDLE.
REQ-035 Force 300 wraps with WRAP_LIMIT=255 -> wrap_count saturates at 255, alarm=1.
REQ-036 reset driven 0 between clock edges while in ALARM -> outputs 0 and state=IDLE before next rising edge; cnt_reset at count 9 mid-run -> no fault, wrap_count unchanged.
